// File: rtl/rom_pkg.sv
// Shared constants and FSM encoding for the ROM burst reader.
package rom_pkg;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ROM_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CAPT  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } rd_state_t;

endpackage

// File: rtl/rom_burst_reader.sv
// Burst read initiator for a registered-output ROM: issues addresses, captures
// each returned word and presents it on a valid/ready stream with a checksum.
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int unsigned ADDR  = ADDR_W,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDR-1:0]  base_addr,
  input  logic [ADDR:0]    len,
  output logic             busy,
  output logic             done,
  output logic             rom_rd,
  output logic [ADDR-1:0]  rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [WIDTH-1:0] checksum
);

  localparam int unsigned CW = ADDR + 1;

  rd_state_t       state;
  rd_state_t       state_n;
  logic [ADDR-1:0] addr_q;
  logic [CW-1:0]   cnt_q;
  logic            accept_c;
  logic            hs_c;

  assign rom_addr = addr_q;

  // Next-state decode; accept_c/hs_c mark start acceptance and stream handshake.
  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    hs_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_n  = (len != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: state_n = CAPT;
      CAPT:  state_n = OUT;
      OUT: begin
        if (m_ready) begin
          hs_c    = 1'b1;
          state_n = (cnt_q == CW'(1)) ? DONE : ISSUE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Control outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      rom_rd  <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      busy    <= (state_n != IDLE);
      done    <= (state_n == DONE);
      rom_rd  <= (state_n == ISSUE) || (state_n == CAPT);
      m_valid <= (state_n == OUT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      cnt_q    <= '0;
      m_data   <= '0;
      checksum <= '0;
    end else begin
      if (accept_c) begin
        checksum <= '0;
        if (len != '0) begin
          addr_q <= base_addr;
          cnt_q  <= len;
        end
      end
      if (state == CAPT) begin
        m_data <= rom_data;
      end
      if (hs_c) begin
        checksum <= checksum + m_data;
        addr_q   <= addr_q + ADDR'(1);
        cnt_q    <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Scoreboard bench for rom_burst_reader with a behavioural 32x8 registered ROM.
module tb_rom_burst_reader;

  localparam int unsigned AW    = rom_pkg::ADDR_W;
  localparam int unsigned DW    = rom_pkg::DATA_W;
  localparam int unsigned DEPTH = rom_pkg::ROM_DEPTH;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          start     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len       = '0;
  logic          busy;
  logic          done;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data  = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready   = 1'b0;
  logic [DW-1:0] checksum;

  logic [DW-1:0] rom_mem [DEPTH];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int start_cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int done_rel = 0;
  int rd_cycles = 0;
  int valid_cycles = 0;
  logic rd_d = 1'b0;

  logic [DW-1:0] exp_data_q [$];
  logic [AW-1:0] exp_addr_q [$];
  logic [DW-1:0] exp_sum_q  [$];
  int            hs_rel_q   [$];

  rom_burst_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rom_rd    (rom_rd),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-output ROM responder.
  always @(posedge clk) if (rom_rd) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops expected addresses, words and checksums as the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (rom_rd) rd_cycles++;
      if (m_valid) begin
        valid_cycles++;
        check("rom_rd_low_while_valid", int'(rom_rd), 0);
      end
      if (rom_rd && !rd_d) begin
        if (exp_addr_q.size() == 0) check("extra_rom_access", exp_addr_q.size(), 1);
        else check("rom_addr", int'(rom_addr), int'(exp_addr_q.pop_front()));
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        hs_rel_q.push_back(cyc - start_cyc);
        if (exp_data_q.size() == 0) check("extra_word", exp_data_q.size(), 1);
        else check("m_data", int'(m_data), int'(exp_data_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - start_cyc;
        check("busy_in_done", int'(busy), 1);
        if (exp_sum_q.size() == 0) check("extra_done", exp_sum_q.size(), 1);
        else check("checksum", int'(checksum), int'(exp_sum_q.pop_front()));
      end
    end
    rd_d = rom_rd;
  end

  task automatic issue_start(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk); #1;
    base_addr = b;
    len       = l;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("burst_completes", int'(done_cnt != d0), 1);
  endtask

  task automatic check_drained(input string name);
    check(name, exp_data_q.size() + exp_addr_q.size() + exp_sum_q.size(), 0);
  endtask

  task automatic check_all_zero();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rom_rd", int'(rom_rd), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_checksum", int'(checksum), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int d0;
    int rd0;
    int v0;
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'(i * 37 + 11);
    rom_mem[0]  = 8'h45;
    rom_mem[1]  = 8'h60;
    rom_mem[2]  = 8'h23;
    rom_mem[3]  = 8'h79;
    rom_mem[4]  = 8'h12;
    rom_mem[5]  = 8'hAB;
    rom_mem[6]  = 8'hCF;
    rom_mem[12] = 8'h34;
    rom_mem[30] = 8'h7C;
    rom_mem[31] = 8'hC3;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero();
    rst = 1'b0;
    m_ready = 1'b1;

    // Basic burst with cycle-accurate timing
    exp_data_q = '{8'h45, 8'h60, 8'h23, 8'h79};
    exp_addr_q = '{5'd0, 5'd1, 5'd2, 5'd3};
    exp_sum_q  = '{8'h41};
    hs_rel_q.delete();
    issue_start(5'd0, 6'd4);
    wait_done(100);
    check("basic_hs_count", hs_rel_q.size(), 4);
    if (hs_rel_q.size() == 4) begin
      check("basic_hs0_cycle", hs_rel_q[0], 3);
      check("basic_hs1_cycle", hs_rel_q[1], 6);
      check("basic_hs2_cycle", hs_rel_q[2], 9);
      check("basic_hs3_cycle", hs_rel_q[3], 12);
    end
    check("basic_done_cycle", done_rel, 13);
    check_drained("basic_drained");
    check("basic_idle_busy", int'(busy), 0);

    // Address wrap-around
    exp_data_q = '{8'h7C, 8'hC3, 8'h45, 8'h60};
    exp_addr_q = '{5'd30, 5'd31, 5'd0, 5'd1};
    exp_sum_q  = '{8'hE4};
    issue_start(5'd30, 6'd4);
    wait_done(100);
    check_drained("wrap_drained");

    // Backpressure on the first word
    m_ready    = 1'b0;
    exp_data_q = '{8'hAB, 8'hCF};
    exp_addr_q = '{5'd5, 5'd6};
    exp_sum_q  = '{8'h7A};
    issue_start(5'd5, 6'd2);
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid_seen", int'(m_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", int'(m_valid), 1);
      check("bp_data_held", int'(m_data), 8'hAB);
      check("bp_rd_low", int'(rom_rd), 0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_done(100);
    check_drained("bp_drained");

    // Reset mid-burst, then restart
    exp_data_q = '{8'h45, 8'h60};
    exp_addr_q = '{5'd0, 5'd1};
    exp_sum_q.delete();
    d0 = hs_cnt;
    issue_start(5'd0, 6'd8);
    n = 0;
    while (hs_cnt < d0 + 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rstb_two_handshakes", hs_cnt - d0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero();
    d0 = done_cnt;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("rstb_no_done", done_cnt - d0, 0);
    check("rstb_idle", int'(busy), 0);
    check_drained("rstb_drained");

    exp_data_q = '{8'h34};
    exp_addr_q = '{5'd12};
    exp_sum_q  = '{8'h34};
    issue_start(5'd12, 6'd1);
    wait_done(100);
    check_drained("restart_drained");

    // Start while busy is ignored
    exp_data_q = '{8'h23, 8'h79, 8'h12};
    exp_addr_q = '{5'd2, 5'd3, 5'd4};
    exp_sum_q  = '{8'hAE};
    issue_start(5'd2, 6'd3);
    @(posedge clk); #1;
    base_addr = 5'd20;
    len       = 6'd5;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    d0 = done_cnt;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("busy_start_no_second_burst", done_cnt - d0, 0);
    check("busy_start_idle", int'(busy), 0);
    check_drained("busy_start_drained");

    // Zero length: done without ROM access, checksum cleared
    exp_sum_q = '{8'h00};
    rd0 = rd_cycles;
    v0  = valid_cycles;
    issue_start(5'd9, 6'd0);
    wait_done(20);
    check("zero_done_cycle", done_rel, 1);
    check("zero_no_rom_rd", rd_cycles - rd0, 0);
    check("zero_no_valid", valid_cycles - v0, 0);
    check_drained("zero_drained");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
